mult_ctrl_accum: RTL

- Sequencer and accumulator for the 4-cycle 8x8 multiplier datapath; sits directly downstream of left_shifter_8_to_16 and consumes its 16-bit data_out.
- Each cycle it selects the operand nibbles for the 4x4 multiplier and the shift code for the shifter.
- It sums the four shifted partial products into a 16-bit product and flags completion.

---
 rtl/mult_ctrl_accum.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_ctrl_accum.sv
// -----------------------------------------------------------------------------
// mult_ctrl_accum
//
// Sequencer and accumulator for the 4-cycle 8x8 multiplier datapath built
// from a 4x4 multiplier and left_shifter_8_to_16. On start it steps through
// four partial-product cycles, selects the operand nibbles and the shift
// code for each one, and sums the shifted partial products into a product.
//
// Ports:
//   clk          system clock, rising edge
//   reset_a      asynchronous reset, active low
//   start        request a new multiply (sampled only in IDLE)
//   shift_in     shifted partial product from the shifter (ACC_W bits)
//   sel          nibble select: sel[0] a hi/lo, sel[1] b hi/lo
//   shift_cntrl  shifter code: 00 none, 01 left 4, 10 left 8
//   product_out  accumulated product (ACC_W bits)
//   busy         high in S0..S3
//   done         one-cycle pulse when product_out is final
//   ovf          sticky carry-out of the accumulator adder
// -----------------------------------------------------------------------------
module mult_ctrl_accum #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset_a,
    input  logic             start,
    input  logic [ACC_W-1:0] shift_in,
    output logic [1:0]       sel,
    output logic [1:0]       shift_cntrl,
    output logic [ACC_W-1:0] product_out,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S0   = 3'd1;
    localparam logic [2:0] S1   = 3'd2;
    localparam logic [2:0] S2   = 3'd3;
    localparam logic [2:0] S3   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]     state;
    logic [2:0]     state_next;
    logic [ACC_W:0] acc_sum;

    // Sum with the carry-out kept as the extra top bit.
    function automatic logic [ACC_W:0] add_with_carry(
        input logic [ACC_W-1:0] x,
        input logic [ACC_W-1:0] y
    );
        add_with_carry = {1'b0, x} + {1'b0, y};
    endfunction

    assign acc_sum = add_with_carry(product_out, shift_in);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? S0 : IDLE;
            S0:      state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = S3;
            S3:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from the registered state only, so an asynchronous
    // reset drives them to their idle values at once.
    always_comb begin
        sel         = 2'b00;
        shift_cntrl = 2'b00;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S0: begin
                busy = 1'b1;
            end
            S1: begin
                sel         = 2'b01;
                shift_cntrl = 2'b01;
                busy        = 1'b1;
            end
            S2: begin
                sel         = 2'b10;
                shift_cntrl = 2'b01;
                busy        = 1'b1;
            end
            S3: begin
                sel         = 2'b11;
                shift_cntrl = 2'b10;
                busy        = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                sel         = 2'b00;
                shift_cntrl = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state       <= IDLE;
            product_out <= '0;
            ovf         <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                // First partial product replaces the previous result.
                S0: begin
                    product_out <= shift_in;
                    ovf         <= 1'b0;
                end
                S1, S2, S3: begin
                    product_out <= acc_sum[ACC_W-1:0];
                    if (acc_sum[ACC_W]) begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                    product_out <= product_out;
                end
            endcase
        end
    end

endmodule
